// File: rtl/tile_run_controller.sv
// Run controller for NUM_TILES Tile instances: reset sequencing, rmc distribution, cycle count, watchdog.
// Optional per-tile completion cycle capture when PER_TILE_CYCLES_EN is defined.
module tile_run_controller #(
  parameter int NUM_TILES = 4,
  parameter int RMC_W     = 32,
  parameter int CYC_W     = 32,
  parameter int RST_HOLD  = 4
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       start,
  input  logic [RMC_W-1:0]           rmc_cfg,
  input  logic [CYC_W-1:0]           timeout_cycles,
  input  logic [NUM_TILES-1:0]       tile_done,
  output logic [NUM_TILES-1:0]       tile_RSTn,
  output logic [NUM_TILES*RMC_W-1:0] tile_rmc,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [NUM_TILES-1:0]       done_mask,
  output logic [CYC_W-1:0]           cycle_count
`ifdef PER_TILE_CYCLES_EN
  ,
  output logic [NUM_TILES*CYC_W-1:0] tile_cycles
`endif
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET_T,
    S_RUN,
    S_DONE
  } state_t;

  state_t                     r_state;
  logic [HW-1:0]              r_hold;
  logic [CYC_W-1:0]           r_limit;
  logic [CYC_W-1:0]           r_cycle_count;
  logic [NUM_TILES-1:0]       r_done_mask;
  logic [NUM_TILES-1:0]       r_tile_rstn;
  logic [NUM_TILES*RMC_W-1:0] r_tile_rmc;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_timeout;

  logic [NUM_TILES-1:0] w_mask_nxt;
  logic                 w_all_done;
  logic                 w_wd_hit;
  logic [CYC_W-1:0]     w_cnt_inc;
  logic                 w_start_ok;
  logic                 w_hold_last;

  assign w_mask_nxt  = r_done_mask | tile_done;
  assign w_all_done  = &w_mask_nxt;
  assign w_wd_hit    = (r_limit != '0) &&
                       (r_cycle_count == (r_limit - CYC_ONE));
  assign w_cnt_inc   = (&r_cycle_count) ? r_cycle_count
                                        : r_cycle_count + CYC_ONE;
  assign w_start_ok  = start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hold_last = (r_hold == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_limit       <= '0;
      r_cycle_count <= '0;
      r_done_mask   <= '0;
      r_tile_rstn   <= '0;
      r_tile_rmc    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state       <= S_RESET_T;
            r_tile_rmc    <= {NUM_TILES{rmc_cfg}};
            r_limit       <= timeout_cycles;
            r_hold        <= '0;
            r_cycle_count <= '0;
            r_done_mask   <= '0;
            r_tile_rstn   <= '0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
          end
        end
        S_RESET_T: begin
          if (w_hold_last) begin
            r_state     <= S_RUN;
            r_tile_rstn <= '1;
          end else begin
            r_hold <= r_hold + HOLD_ONE;
          end
        end
        S_RUN: begin
          r_cycle_count <= w_cnt_inc;
          r_done_mask   <= w_mask_nxt;
          // completion takes priority over a coincident watchdog expiry
          if (w_all_done) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_wd_hit) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_timeout   <= 1'b1;
            r_tile_rstn <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tile_RSTn   = r_tile_rstn;
  assign tile_rmc    = r_tile_rmc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign done_mask   = r_done_mask;
  assign cycle_count = r_cycle_count;

`ifdef PER_TILE_CYCLES_EN
  logic [CYC_W-1:0] r_tile_cycles [NUM_TILES];

  // a slot latches the count of the RUN cycle in which its tile first reports done
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < NUM_TILES; i++) r_tile_cycles[i] <= '0;
    end else if (w_start_ok) begin
      for (int i = 0; i < NUM_TILES; i++) r_tile_cycles[i] <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < NUM_TILES; i++) begin
        if (tile_done[i] && !r_done_mask[i]) r_tile_cycles[i] <= w_cnt_inc;
      end
    end
  end

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_tc
    assign tile_cycles[g*CYC_W +: CYC_W] = r_tile_cycles[g];
  end
`endif

endmodule

// File: tb/tb_tile_run_controller.sv
// Self-checking bench for tile_run_controller: run-level timeline model with random schedules.
// Define PER_TILE_CYCLES_EN to also check the per-tile cycle capture.
module tb_tile_run_controller;
  localparam int NT = 4;
  localparam int RW = 32;
  localparam int CW = 8;
  localparam int RH = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int BIG = 1 << 30;

  logic                clk = 1'b0;
  logic                RST;
  logic                start;
  logic [RW-1:0]       rmc_cfg;
  logic [CW-1:0]       timeout_cycles;
  logic [NT-1:0]       tile_done;
  logic [NT-1:0]       tile_RSTn;
  logic [NT*RW-1:0]    tile_rmc;
  logic                busy;
  logic                done;
  logic                timeout;
  logic [NT-1:0]       done_mask;
  logic [CW-1:0]       cycle_count;
`ifdef PER_TILE_CYCLES_EN
  logic [NT*CW-1:0]    tile_cycles;
`endif

  tile_run_controller #(
    .NUM_TILES(NT), .RMC_W(RW), .CYC_W(CW), .RST_HOLD(RH)
  ) dut (
    .clk(clk), .RST(RST), .start(start), .rmc_cfg(rmc_cfg),
    .timeout_cycles(timeout_cycles), .tile_done(tile_done),
    .tile_RSTn(tile_RSTn), .tile_rmc(tile_rmc), .busy(busy),
    .done(done), .timeout(timeout), .done_mask(done_mask),
    .cycle_count(cycle_count)
`ifdef PER_TILE_CYCLES_EN
    , .tile_cycles(tile_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int f [NT];
  logic [RW-1:0] cur_rmc;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // ph: 0 reset phase, 1 run cycle k, 2 done after k run cycles, 3 idle
  task automatic check_state(input int ph, input int k, input logic to);
    logic [NT-1:0]    e_mask;
    logic [NT-1:0]    e_rstn;
    logic [NT*RW-1:0] e_rmc;
    logic [NT*CW-1:0] e_tc;
    int               e_cnt;
    bit               fin;
    e_mask = '0;
    e_tc = '0;
    for (int i = 0; i < NT; i++) begin
      fin = (f[i] != 0) &&
            (((ph == 1) && (f[i] < k)) || ((ph == 2) && (f[i] <= k)));
      e_mask[i] = fin;
      if (fin) e_tc[i*CW +: CW] = CW'(sat(f[i]));
    end
    e_cnt = (ph == 1) ? sat(k - 1) : (ph == 2) ? sat(k) : 0;
    e_rstn = ((ph == 1) || ((ph == 2) && !to)) ? '1 : '0;
    e_rmc = (ph == 3) ? '0 : {NT{cur_rmc}};
    chk("busy", busy, (ph == 0) || (ph == 1));
    chk("done", done, ph == 2);
    chk("timeout", timeout, (ph == 2) && to);
    chk("tile_RSTn", tile_RSTn, e_rstn);
    chk("done_mask", done_mask, e_mask);
    chk("cycle_count", cycle_count, e_cnt);
    chk("tile_rmc", tile_rmc, e_rmc);
`ifdef PER_TILE_CYCLES_EN
    chk("tile_cycles", tile_cycles, e_tc);
`endif
  endtask

  task automatic run_one(input logic [RW-1:0] rmc, input int lim,
                         input int f0, input int f1, input int f2,
                         input int f3, output int kk, output logic to);
    int c;
    int w;
    int ph;
    int k;
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    c = 0;
    for (int i = 0; i < NT; i++) begin
      if (f[i] == 0) c = BIG;
      else if (c != BIG && f[i] > c) c = f[i];
    end
    w = (lim != 0) ? lim : BIG;
    kk = (c < w) ? c : w;
    to = (c > kk);
    cur_rmc = rmc;
    start = 1'b1;
    rmc_cfg = rmc;
    timeout_cycles = CW'(lim);
    tile_done = NT'($urandom);
    tick();
    start = 1'b0;
    rmc_cfg = $urandom;
    timeout_cycles = CW'($urandom);
    for (int n = 0; n <= RH + kk + 2; n++) begin
      if (n < RH) begin ph = 0; k = 0; end
      else if (n < RH + kk) begin ph = 1; k = n - RH + 1; end
      else begin ph = 2; k = kk; end
      check_state(ph, k, to);
      if (ph == 1) begin
        for (int i = 0; i < NT; i++)
          tile_done[i] = (f[i] != 0) &&
                         ((k == f[i]) || ((k > f[i]) && $urandom_range(1, 0) == 1));
      end else begin
        tile_done = NT'($urandom);
      end
      start = (ph != 2) && ($urandom_range(3, 0) == 0);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int   kk;
    logic to;
    int   lim;
    int   r [NT];
    RST = 1'b1;
    start = 1'b0;
    rmc_cfg = 32'hDEAD_BEEF;
    timeout_cycles = '0;
    tile_done = '0;
    for (int i = 0; i < NT; i++) f[i] = 0;
    cur_rmc = '0;
    for (int n = 0; n < 3; n++) begin
      tile_done = NT'($urandom);
      start = $urandom_range(1, 0) == 1;
      tick();
      check_state(3, 0, 1'b0);
    end
    RST = 1'b0;
    start = 1'b0;
    tick();
    check_state(3, 0, 1'b0);

    run_one(32'd4096, 0, 10, 20, 30, 40, kk, to);
    chk("t3_mask", done_mask, 4'hF);
    chk("t3_count", cycle_count, 40);
    chk("t3_timeout", timeout, 1'b0);
    chk("t3_done", done, 1'b1);
    chk("t2_rmc0", tile_rmc[31:0], 32'd4096);
    chk("t2_rmc3", tile_rmc[127:96], 32'd4096);
`ifdef PER_TILE_CYCLES_EN
    chk("t6_cycles", tile_cycles, 32'h281E140A);
`endif

    run_one(32'd7, 25, 3, 9, 12, 0, kk, to);
    chk("t4_count", cycle_count, 25);
    chk("t4_mask", done_mask, 4'h7);
    chk("t4_timeout", timeout, 1'b1);
    chk("t4_rstn", tile_RSTn, 4'h0);
`ifdef PER_TILE_CYCLES_EN
    chk("t6_cycles_to", tile_cycles, 32'h000C0903);
`endif

    run_one(32'd5, 25, 4, 25, 11, 17, kk, to);
    chk("t5_tie_timeout", timeout, 1'b0);
    chk("t5_tie_done", done, 1'b1);
    chk("t5_tie_count", cycle_count, 25);

    run_one(32'd1, 0, 300, 2, 3, 4, kk, to);
    chk("sat_count", cycle_count, 8'hFF);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NT; i++)
        r[i] = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(60, 1);
      lim = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(70, 1);
      if (lim == 0 && (r[0] == 0 || r[1] == 0 || r[2] == 0 || r[3] == 0))
        lim = $urandom_range(70, 1);
      run_one($urandom, lim, r[0], r[1], r[2], r[3], kk, to);
    end

    cur_rmc = 32'h1234_5678;
    start = 1'b1;
    rmc_cfg = cur_rmc;
    timeout_cycles = '0;
    tile_done = '0;
    tick();
    start = 1'b0;
    for (int n = 0; n < RH + 5; n++) tick();
    chk("mid_busy", busy, 1'b1);
    chk("mid_rstn", tile_RSTn, 4'hF);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_state(3, 0, 1'b0);
    tick();
    check_state(3, 0, 1'b0);

    run_one(32'hA5A5_A5A5, 30, 6, 7, 8, 9, kk, to);
    chk("recover_count", cycle_count, 9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
